// File: rtl/video_mnist_color_ctl.sv
// Parameter controller for the MNIST color core: host writes are held in a shadow
// set and applied only on an accepted start-of-frame beat; optional auto mode cycling.
module video_mnist_color_ctl #(
  parameter int                  TCOUNT_WIDTH    = 4,
  parameter int                  FRAME_CNT_WIDTH = 16,
  parameter logic [1:0]          INIT_MODE       = 2'b00,
  parameter logic [TCOUNT_WIDTH-1:0] INIT_TH     = 4'd8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_wr_en,
  input  logic [1:0]                 s_wr_mode,
  input  logic [TCOUNT_WIDTH-1:0]    s_wr_th,
  input  logic                       auto_en,
  input  logic [FRAME_CNT_WIDTH-1:0] auto_interval,
  input  logic                       mon_tuser0,
  input  logic                       mon_tvalid,
  input  logic                       mon_tready,
  output logic [1:0]                 param_mode,
  output logic [TCOUNT_WIDTH-1:0]    param_th,
  output logic                       pending,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       frame_start
);

  // Handshake: a monitored beat counts only when mon_tvalid and mon_tready are
  // both high on the same rising edge; a frame start is such a beat with tuser0 set.
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                     state;
  logic [1:0]                 shadow_mode;
  logic [TCOUNT_WIDTH-1:0]    shadow_th;
  logic [FRAME_CNT_WIDTH-1:0] auto_cnt;
  logic                       fs;
  logic                       auto_active;
  logic                       auto_hit;

  assign fs          = mon_tvalid & mon_tready & mon_tuser0;
  assign auto_active = auto_en && (auto_interval != '0);
  assign auto_hit    = (auto_cnt == auto_interval - 1'b1);
  assign pending     = (state == PEND);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      param_mode  <= INIT_MODE;
      param_th    <= INIT_TH;
      shadow_mode <= INIT_MODE;
      shadow_th   <= INIT_TH;
      frame_count <= '0;
      frame_start <= 1'b0;
      auto_cnt    <= '0;
    end else begin
      frame_start <= fs;
      if (fs) frame_count <= frame_count + 1'b1;

      // Disabled auto stepping parks the counter so re-enabling starts a fresh interval.
      if (!auto_active) auto_cnt <= '0;

      case (state)
        IDLE: begin
          if (s_wr_en) begin
            shadow_mode <= s_wr_mode;
            shadow_th   <= s_wr_th;
            state       <= PEND;
          end
          if (auto_active && fs) begin
            if (auto_hit) begin
              param_mode <= param_mode + 2'd1;
              auto_cnt   <= '0;
            end else begin
              auto_cnt <= auto_cnt + 1'b1;
            end
          end
        end
        PEND: begin
          // Applying reads the old shadow; a same-cycle write refills it and keeps PEND.
          if (fs) begin
            param_mode <= shadow_mode;
            param_th   <= shadow_th;
            auto_cnt   <= '0;
            if (!s_wr_en) state <= IDLE;
          end
          if (s_wr_en) begin
            shadow_mode <= s_wr_mode;
            shadow_th   <= s_wr_th;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/video_mnist_color_ctl.md
VIDEO_MNIST_COLOR_CTL -- requirements
Module: video_mnist_color_ctl

Interface
REQ-001 Parameter TCOUNT_WIDTH, default 4, width of the threshold value; equals the color core's TCOUNT_WIDTH.
REQ-002 Parameter FRAME_CNT_WIDTH, default 16, width of the frame counter and the auto interval.
REQ-003 Parameter INIT_MODE, default 2'b00, reset value of param_mode.
REQ-004 Parameter INIT_TH, default 4'd8 (TCOUNT_WIDTH bits), reset value of param_th.
REQ-005 aclk  in  1  single clock; all logic is on the rising edge.
REQ-006 areset  in  1  reset, asynchronous and active-high.
REQ-007 s_wr_en  in  1  host write strobe for a new parameter set.
REQ-008 s_wr_mode  in  2  requested display mode.
REQ-009 s_wr_th  in  TCOUNT_WIDTH  requested count threshold.
REQ-010 auto_en  in  1  enables automatic mode cycling.
REQ-011 auto_interval  in  FRAME_CNT_WIDTH  frames per auto step; 0 disables stepping.
REQ-012 mon_tuser0  in  1  snooped tuser[0] (start of frame) at the color core input.
REQ-013 mon_tvalid  in  1  snooped tvalid at the color core input.
REQ-014 mon_tready  in  1  snooped tready at the color core input.
REQ-015 param_mode  out  2  mode to the color core.
REQ-016 param_th  out  TCOUNT_WIDTH  threshold to the color core.
REQ-017 pending  out  1  high while a host write awaits a frame start.
REQ-018 frame_count  out  FRAME_CNT_WIDTH  count of frame starts, wraps.
REQ-019 frame_start  out  1  one-cycle pulse following each frame start.

Function
REQ-020 fs = mon_tvalid & mon_tready & mon_tuser0; a frame start is one accepted SOF beat; fs is not counted unless both tvalid and tready are high.
REQ-021 FSM states: IDLE (no pending write) and PEND (shadow set waiting); pending = (state == PEND).
REQ-022 IDLE with s_wr_en: shadow_mode/shadow_th <= s_wr_mode/s_wr_th; next state PEND.
REQ-023 PEND with s_wr_en and no fs: shadow is overwritten (latest write wins); stay in PEND.
REQ-024 PEND with fs and no s_wr_en: param_mode/param_th <= shadow; auto counter <= 0; next state IDLE.
REQ-025 PEND with fs and s_wr_en together: the old shadow is applied to the outputs, the new write is captured into shadow, state stays PEND.
REQ-026 IDLE with fs and s_wr_en together: the write is captured and the state goes to PEND; it is not applied on this fs.
REQ-027 param_mode and param_th are registered; the new values take effect from the beat after the SOF beat. The SOF beat itself uses the old values.
REQ-028 Auto stepping applies only in IDLE with auto_en=1 and auto_interval!=0. Each fs increments auto_cnt.
REQ-029 When auto_cnt == auto_interval-1 at fs: param_mode <= param_mode+1 (modulo 4, 3 wraps to 0) and auto_cnt <= 0. param_th is unchanged by auto stepping.
REQ-030 auto_en=0 holds auto_cnt at 0. If auto_interval changes mid-count, the new value is compared from the next fs.
REQ-031 In PEND, auto stepping is suppressed; the host write has priority.
REQ-032 frame_count increments by 1 on every fs, in any state; all-ones wraps to 0.
REQ-033 frame_start is registered and equals fs delayed by one cycle.

Reset
REQ-034 While areset=1 (asynchronously): state IDLE, param_mode=INIT_MODE, param_th=INIT_TH, shadow=INIT values, pending=0, frame_count=0, frame_start=0, auto_cnt=0.
REQ-035 Reset asserted while in PEND discards the pending write; the outputs return to their INIT values immediately, without waiting for a clock edge.
REQ-036 After reset deassertion, fs and s_wr_en are honoured from the first rising edge.

Verification
REQ-037 Reset, then s_wr_en with mode=3, th=5 mid-frame, no fs for 100 cycles -> pending=1, param_mode=0 and param_th=8 unchanged; on the fs beat -> next cycle param_mode=3, param_th=5, pending=0, frame_start=1 for one cycle.
REQ-038 Writes (1,2) then (2,7) before one fs -> only (2,7) is applied; frame_count increments by exactly 1.
REQ-039 mon_tuser0=1 with mon_tvalid=1 and mon_tready=0 for 10 cycles, then mon_tready=1 for one cycle -> exactly one fs: frame_count +1, one frame_start pulse.
REQ-040 auto_en=1, auto_interval=3, mode=2, 7 fs events -> mode 2,2,3,3,3,0,0 after each fs (steps on fs #3 and #6); auto_interval=0 -> mode never changes.
REQ-041 In PEND, s_wr_en and fs in the same cycle -> old shadow applied to the outputs, new values held, pending stays 1 and is applied on the following fs.
REQ-042 Assert areset asynchronously between clock edges while pending=1 -> outputs read INIT values immediately, pending=0, and the discarded write is never applied.
